pwm_generator: RTL and testbench

Cycle-accurate PWM waveform generator that consumes the two decoded write strobes and the 32-bit store data issued by the peripheral manager for PWM port 1, and drives the physical PWM pin. On/off durations are written into shadow registers and transferred into the active registers only at a period boundary, so the waveform never glitches mid-period. It also reports period completion and activity to the rest of the SoC.

---
 rtl/pwm_generator.sv | 219 +++++++++++++++++++++
 tb/tb_pwm_generator.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/pwm_generator.sv
// rtl/pwm_generator.sv - PWM waveform generator with shadowed on/off counts
//
// Build option: PWM_SYNC_UPDATE_EN
//   defined   : strobes only update the shadow registers; the active counts
//               are refreshed from the shadows at each period boundary.
//   undefined : strobes also write the active counts directly and the period
//               restarts from the new values one edge after the strobe.

module pwm_generator #(
   parameter int CNT_WIDTH = 32
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        wr_on,
   input  logic        wr_off,
   input  logic [31:0] wr_data,
   output logic        port_output,
   output logic        period_done,
   output logic        busy
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_HIGH = 2'd1,
      ST_LOW  = 2'd2
   } state_e;

   localparam logic [CNT_WIDTH-1:0] CNT_ZERO = '0;
   localparam logic [CNT_WIDTH-1:0] CNT_ONE  = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

   // Store data narrowed to the counter width.
   logic [CNT_WIDTH-1:0] wr_val;

   // Shadow registers written by the strobes.
   logic [CNT_WIDTH-1:0] on_shadow_q,  on_shadow_d;
   logic [CNT_WIDTH-1:0] off_shadow_q, off_shadow_d;

   // Active counts used by the running period.
   logic [CNT_WIDTH-1:0] on_active_q,  on_active_d;
   logic [CNT_WIDTH-1:0] off_active_q, off_active_d;

   // Down-counter and FSM state.
   logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
   state_e               state_q, state_d;

   // Registered outputs.
   logic port_output_q, port_output_d;
   logic period_done_q, period_done_d;
   logic busy_q,        busy_d;

`ifndef PWM_SYNC_UPDATE_EN
   // A strobe seen at the previous edge forces a restart at this edge.
   logic restart_q, restart_d;
`endif

   // Where a fresh period starts, decided from the shadow contents.
   logic                 shadow_any;
   state_e               start_state;
   logic [CNT_WIDTH-1:0] start_cnt;

   // Boundary/reload bookkeeping for the current edge.
   logic boundary;
   logic reload;

   assign wr_val = wr_data[CNT_WIDTH-1:0];

   // Shadow register next-state: each strobe loads its own register.
   always_comb begin
      on_shadow_d  = on_shadow_q;
      off_shadow_d = off_shadow_q;
      if (wr_on) begin
         on_shadow_d = wr_val;
      end
      if (wr_off) begin
         off_shadow_d = wr_val;
      end
   end

   // Start rule: HIGH if on is non-zero, else LOW if off is non-zero, else IDLE.
   always_comb begin
      shadow_any  = (on_shadow_q != CNT_ZERO) || (off_shadow_q != CNT_ZERO);
      start_state = ST_IDLE;
      start_cnt   = CNT_ZERO;
      if (on_shadow_q != CNT_ZERO) begin
         start_state = ST_HIGH;
         start_cnt   = on_shadow_q - CNT_ONE;
      end else if (off_shadow_q != CNT_ZERO) begin
         start_state = ST_LOW;
         start_cnt   = off_shadow_q - CNT_ONE;
      end
   end

   // FSM next-state: count down each phase, reload actives at the boundary.
   always_comb begin
      state_d       = state_q;
      cnt_d         = cnt_q;
      on_active_d   = on_active_q;
      off_active_d  = off_active_q;
      period_done_d = 1'b0;
      boundary      = 1'b0;
      reload        = 1'b0;
`ifndef PWM_SYNC_UPDATE_EN
      restart_d     = wr_on | wr_off;
`endif

      case (state_q)
         ST_IDLE: begin
            if (shadow_any) begin
               reload = 1'b1;
            end
         end
         ST_HIGH: begin
            if (cnt_q == CNT_ZERO) begin
               if (off_active_q != CNT_ZERO) begin
                  state_d = ST_LOW;
                  cnt_d   = off_active_q - CNT_ONE;
               end else begin
                  boundary = 1'b1;
               end
            end else begin
               cnt_d = cnt_q - CNT_ONE;
            end
         end
         ST_LOW: begin
            if (cnt_q == CNT_ZERO) begin
               boundary = 1'b1;
            end else begin
               cnt_d = cnt_q - CNT_ONE;
            end
         end
         default: begin
            state_d = ST_IDLE;
            cnt_d   = CNT_ZERO;
         end
      endcase

      if (boundary) begin
         period_done_d = 1'b1;
         reload        = 1'b1;
      end

`ifndef PWM_SYNC_UPDATE_EN
      // An aborted period is not reported as done.
      if (restart_q) begin
         period_done_d = 1'b0;
         reload        = 1'b1;
      end
`endif

      // Shadows as they stood before this edge; a write landing now waits.
      if (reload) begin
         on_active_d  = on_shadow_q;
         off_active_d = off_shadow_q;
         state_d      = start_state;
         cnt_d        = start_cnt;
      end

`ifndef PWM_SYNC_UPDATE_EN
      // Direct writes into the active counts take precedence over a reload.
      if (wr_on) begin
         on_active_d = wr_val;
      end
      if (wr_off) begin
         off_active_d = wr_val;
      end
`endif

      port_output_d = (state_d == ST_HIGH);
      busy_d        = (state_d != ST_IDLE);
   end

   // Shadow registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         on_shadow_q  <= CNT_ZERO;
         off_shadow_q <= CNT_ZERO;
      end else begin
         on_shadow_q  <= on_shadow_d;
         off_shadow_q <= off_shadow_d;
      end
   end

   // FSM state, counter, active counts and registered outputs.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q       <= ST_IDLE;
         cnt_q         <= CNT_ZERO;
         on_active_q   <= CNT_ZERO;
         off_active_q  <= CNT_ZERO;
         port_output_q <= 1'b0;
         period_done_q <= 1'b0;
         busy_q        <= 1'b0;
      end else begin
         state_q       <= state_d;
         cnt_q         <= cnt_d;
         on_active_q   <= on_active_d;
         off_active_q  <= off_active_d;
         port_output_q <= port_output_d;
         period_done_q <= period_done_d;
         busy_q        <= busy_d;
      end
   end

`ifndef PWM_SYNC_UPDATE_EN
   // Pending restart flag.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         restart_q <= 1'b0;
      end else begin
         restart_q <= restart_d;
      end
   end
`endif

   assign port_output = port_output_q;
   assign period_done = period_done_q;
   assign busy        = busy_q;

endmodule

// File: tb/tb_pwm_generator.sv
// tb/tb_pwm_generator.sv - directed self-checking bench for pwm_generator

module tb_pwm_generator;

   logic        clk;
   logic        rst;
   logic        wr_on;
   logic        wr_off;
   logic [31:0] wr_data;
   logic        port_output;
   logic        period_done;
   logic        busy;

   int vectors;
   int miscompares;

   pwm_generator #(.CNT_WIDTH(32)) dut (
      .clk         (clk),
      .rst         (rst),
      .wr_on       (wr_on),
      .wr_off      (wr_off),
      .wr_data     (wr_data),
      .port_output (port_output),
      .period_done (period_done),
      .busy        (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Advance to the next negedge showing period_done, bounded.
   task automatic wait_pd(input string name);
      int n;
      n = 0;
      while (period_done !== 1'b1 && n < 200) begin
         @(negedge clk);
         n++;
      end
      if (period_done !== 1'b1) begin
         vectors++;
         miscompares++;
         $display("FAIL %s: timeout waiting for period_done", name);
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      @(negedge clk);
      @(negedge clk);
      vectors++;
      if ({port_output, period_done, busy} !== 3'b000) begin
         miscompares++;
         $display("FAIL reset_hold: got {out,pd,busy}=%b want 000", {port_output, period_done, busy});
      end
      rst = 1'b0;
      @(negedge clk);
      @(negedge clk);
      vectors++;
      if ({port_output, period_done, busy} !== 3'b000) begin
         miscompares++;
         $display("FAIL reset_release_idle: got {out,pd,busy}=%b want 000", {port_output, period_done, busy});
      end
   endtask

   task automatic test_start_3_2();
      logic [9:0] eo;
      logic [9:0] ep;
      eo = 10'b1110011100;
      ep = 10'b1000010000;
      wr_on = 1'b1; wr_data = 32'd3;
      @(negedge clk);
      wr_on = 1'b0; wr_off = 1'b1; wr_data = 32'd2;
      vectors++;
      if ({port_output, busy} !== 2'b00) begin
         miscompares++;
         $display("FAIL start_latency_e0: got {out,busy}=%b want 00", {port_output, busy});
      end
      @(negedge clk);
      wr_off = 1'b0;
      vectors++;
      if ({port_output, busy} !== 2'b11) begin
         miscompares++;
         $display("FAIL start_latency_e1: got {out,busy}=%b want 11", {port_output, busy});
      end
      wait_pd("start_3_2");
      for (int i = 0; i < 10; i++) begin
         vectors++;
         if ({port_output, period_done, busy} !== {eo[9-i], ep[9-i], 1'b1}) begin
            miscompares++;
            $display("FAIL wave_3_2 cyc %0d: got {out,pd,busy}=%b want %b", i,
                     {port_output, period_done, busy}, {eo[9-i], ep[9-i], 1'b1});
         end
         @(negedge clk);
      end
   endtask

   task automatic test_midperiod_update();
      logic [7:0] eo;
      logic [7:0] ep;
`ifdef PWM_SYNC_UPDATE_EN
      eo = 8'b10010010;
      ep = 8'b00010010;
`else
      eo = 8'b11001001;
      ep = 8'b00001001;
`endif
      wait_pd("midperiod_sync");
      @(negedge clk);
      wr_on = 1'b1; wr_data = 32'd1;
      @(negedge clk);
      wr_on = 1'b0;
      for (int i = 0; i < 8; i++) begin
         vectors++;
         if ({port_output, period_done} !== {eo[7-i], ep[7-i]}) begin
            miscompares++;
            $display("FAIL midperiod_update cyc %0d: got {out,pd}=%b want %b", i + 2,
                     {port_output, period_done}, {eo[7-i], ep[7-i]});
         end
         @(negedge clk);
      end
   endtask

   task automatic test_const_high_and_stop();
      logic [7:0] eo;
      logic [7:0] ep;
      logic [3:0] so;
      logic [3:0] sb;
      logic [3:0] sp;
      eo = 8'b11111111;
      ep = 8'b10001000;
`ifdef PWM_SYNC_UPDATE_EN
      so = 4'b1100; sb = 4'b1100; sp = 4'b0010;
`else
      so = 4'b1000; sb = 4'b1000; sp = 4'b0000;
`endif
      wr_on = 1'b1; wr_data = 32'd4;
      @(negedge clk);
      wr_on = 1'b0; wr_off = 1'b1; wr_data = 32'd0;
      @(negedge clk);
      wr_off = 1'b0;
      wait_pd("const_high_a");
      @(negedge clk);
      wait_pd("const_high_b");
      for (int i = 0; i < 8; i++) begin
         vectors++;
         if ({port_output, period_done, busy} !== {eo[7-i], ep[7-i], 1'b1}) begin
            miscompares++;
            $display("FAIL const_high cyc %0d: got {out,pd,busy}=%b want %b", i,
                     {port_output, period_done, busy}, {eo[7-i], ep[7-i], 1'b1});
         end
         @(negedge clk);
      end
      wait_pd("stop_sync");
      @(negedge clk);
      wr_on = 1'b1; wr_data = 32'd0;
      @(negedge clk);
      wr_on = 1'b0;
      for (int i = 0; i < 4; i++) begin
         vectors++;
         if ({port_output, period_done, busy} !== {so[3-i], sp[3-i], sb[3-i]}) begin
            miscompares++;
            $display("FAIL stop_to_idle cyc %0d: got {out,pd,busy}=%b want %b", i + 2,
                     {port_output, period_done, busy}, {so[3-i], sp[3-i], sb[3-i]});
         end
         @(negedge clk);
      end
   endtask

   task automatic test_boundary_write();
      logic [7:0] eo;
      logic [7:0] ep;
`ifdef PWM_SYNC_UPDATE_EN
      eo = 8'b11110011;
      ep = 8'b10100010;
`else
      eo = 8'b11100110;
      ep = 8'b10000100;
`endif
      wr_on = 1'b1; wr_data = 32'd2;
      @(negedge clk);
      wr_on = 1'b0;
      wait_pd("boundary_sync");
      @(negedge clk);
      wr_off = 1'b1; wr_data = 32'd2;
      @(negedge clk);
      wr_off = 1'b0;
      for (int i = 0; i < 8; i++) begin
         vectors++;
         if ({port_output, period_done, busy} !== {eo[7-i], ep[7-i], 1'b1}) begin
            miscompares++;
            $display("FAIL boundary_write cyc %0d: got {out,pd,busy}=%b want %b", i + 2,
                     {port_output, period_done, busy}, {eo[7-i], ep[7-i], 1'b1});
         end
         @(negedge clk);
      end
   endtask

   task automatic test_both_strobes();
      logic [10:0] eo;
      logic [10:0] ep;
      eo = 11'b11111000001;
      ep = 11'b10000000001;
      wr_on = 1'b1; wr_off = 1'b1; wr_data = 32'd5;
      @(negedge clk);
      wr_on = 1'b0; wr_off = 1'b0;
      wait_pd("both_a");
      @(negedge clk);
      wait_pd("both_b");
      for (int i = 0; i < 11; i++) begin
         vectors++;
         if ({port_output, period_done, busy} !== {eo[10-i], ep[10-i], 1'b1}) begin
            miscompares++;
            $display("FAIL both_strobes cyc %0d: got {out,pd,busy}=%b want %b", i,
                     {port_output, period_done, busy}, {eo[10-i], ep[10-i], 1'b1});
         end
         @(negedge clk);
      end
   endtask

   task automatic test_async_reset();
      wait_pd("async_sync");
      vectors++;
      if ({port_output, period_done, busy} !== 3'b111) begin
         miscompares++;
         $display("FAIL pre_reset: got {out,pd,busy}=%b want 111", {port_output, period_done, busy});
      end
      rst = 1'b1;
      #1;
      vectors++;
      if ({port_output, period_done, busy} !== 3'b000) begin
         miscompares++;
         $display("FAIL async_reset: got {out,pd,busy}=%b want 000", {port_output, period_done, busy});
      end
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         vectors++;
         if ({port_output, period_done, busy} !== 3'b000) begin
            miscompares++;
            $display("FAIL post_reset_idle cyc %0d: got {out,pd,busy}=%b want 000", i,
                     {port_output, period_done, busy});
         end
      end
   endtask

   initial begin
      vectors     = 0;
      miscompares = 0;
      rst         = 1'b1;
      wr_on       = 1'b0;
      wr_off      = 1'b0;
      wr_data     = 32'd0;
      test_reset();
      test_start_3_2();
      test_midperiod_update();
      test_const_high_and_stop();
      test_boundary_write();
      test_both_strobes();
      test_async_reset();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
